// File: rtl/ir_pkg.sv
// Shared IR definitions: emulator FSM encodings, charge qualification default
// and the channel count used by the IR controller.
package ir_pkg;

  localparam int unsigned CHARGE_MIN_DEFAULT = 160;
  localparam int unsigned IR_NUM_CHANNELS    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHARGE  = 2'd1,
    ST_DECAY   = 2'd2,
    ST_RELEASE = 2'd3
  } ir_state_e;

endpackage

// File: rtl/ir_sync.sv
// Two-flop level synchronizer, shared by the emulator and the reader side.
module ir_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ir_sensor_emulator.sv
// Emulates a QTR-style IR reflectance sensor: qualifies a host charge pulse,
// holds the RC line high for ttd_active cycles, then hands it back.
module ir_sensor_emulator
  import ir_pkg::*;
#(
  parameter int unsigned CHARGE_MIN = CHARGE_MIN_DEFAULT,
  parameter int unsigned TTD_W      = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [TTD_W-1:0] ttd_cfg,
  input  logic             ttd_load,
  inout  wire              sensor,
  output logic [TTD_W-1:0] ttd_active,
  output logic             busy,
  output logic             cycle_done,
  output logic             charge_err,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(CHARGE_MIN + 1);

  ir_state_e        state_q, state_d;
  logic [CW-1:0]    charge_cnt_q, charge_cnt_d;
  logic [TTD_W-1:0] decay_cnt_q, decay_cnt_d;
  logic [TTD_W-1:0] ttd_active_q;
  logic [1:0]       rel_cnt_q, rel_cnt_d;
  logic             armed_q, armed_d;
  logic             drive_q, drive_d;
  logic             busy_q, busy_d;
  logic             cycle_done_q, cycle_done_d;
  logic             charge_err_q, charge_err_d;
  logic             overrun_q, overrun_d;
  logic             s_line;

  ir_sync #(.W(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (sensor),
    .q_o   (s_line)
  );

  // Open-drain style: only ever 1 or released to the board pull-down.
  assign sensor = drive_q ? 1'b1 : 1'bz;

  always_comb begin
    state_d      = state_q;
    charge_cnt_d = charge_cnt_q;
    decay_cnt_d  = decay_cnt_q;
    rel_cnt_d    = rel_cnt_q;
    armed_d      = armed_q;
    drive_d      = 1'b0;
    cycle_done_d = 1'b0;
    charge_err_d = 1'b0;
    overrun_d    = overrun_q;

    if (!enable) begin
      state_d      = ST_IDLE;
      charge_cnt_d = '0;
      decay_cnt_d  = '0;
      rel_cnt_d    = 2'd0;
      armed_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Re-arm only after a low sample so one host pulse is never counted twice.
          if (!s_line) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d      = ST_CHARGE;
            charge_cnt_d = CW'(1);
            armed_d      = 1'b0;
          end
        end
        ST_CHARGE: begin
          if (!s_line) begin
            charge_err_d = 1'b1;
            charge_cnt_d = '0;
            state_d      = ST_IDLE;
          end else begin
            if (charge_cnt_q != CW'(CHARGE_MIN)) begin
              charge_cnt_d = charge_cnt_q + CW'(1);
            end
            if (charge_cnt_d == CW'(CHARGE_MIN)) begin
              state_d     = ST_DECAY;
              decay_cnt_d = ttd_active_q;
              drive_d     = (ttd_active_q != '0);
            end
          end
        end
        ST_DECAY: begin
          if (decay_cnt_q != '0) begin
            decay_cnt_d = decay_cnt_q - TTD_W'(1);
            drive_d     = (decay_cnt_d != '0);
          end else begin
            state_d   = ST_RELEASE;
            rel_cnt_d = 2'd0;
          end
        end
        ST_RELEASE: begin
          // First cycle waits out synchronizer latency from the end of drive.
          if (rel_cnt_q == 2'd0) begin
            rel_cnt_d = 2'd1;
          end else if (!s_line) begin
            cycle_done_d = 1'b1;
            charge_cnt_d = '0;
            state_d      = ST_IDLE;
          end else begin
            if (rel_cnt_q == 2'd1) begin
              overrun_d = 1'b1;
            end
            rel_cnt_d = 2'd2;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      charge_cnt_q <= '0;
      decay_cnt_q  <= '0;
      ttd_active_q <= '0;
      rel_cnt_q    <= 2'd0;
      armed_q      <= 1'b0;
      drive_q      <= 1'b0;
      busy_q       <= 1'b0;
      cycle_done_q <= 1'b0;
      charge_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      charge_cnt_q <= charge_cnt_d;
      decay_cnt_q  <= decay_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      armed_q      <= armed_d;
      drive_q      <= drive_d;
      busy_q       <= busy_d;
      cycle_done_q <= cycle_done_d;
      charge_err_q <= charge_err_d;
      overrun_q    <= overrun_d;
      if (ttd_load) begin
        ttd_active_q <= ttd_cfg;
      end
    end
  end

  assign ttd_active = ttd_active_q;
  assign busy       = busy_q;
  assign cycle_done = cycle_done_q;
  assign charge_err = charge_err_q;
  assign overrun    = overrun_q;

endmodule
